// File: rtl/mips_ldst_seq.sv
// mips_ldst_seq: issues LW/SW sweeps to the single-cycle MIPS core, then reads back regfile/dmem and checks them.
// Build option: define LDST_SEQ_STOP_ON_ERR_EN to end the check phase at the first mismatch.
module mips_ldst_seq #(
  parameter int NUM_OPS   = 5,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 64,
  parameter int MEM_AW    = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [4:0]        chk_reg_idx,
  output logic [MEM_AW-1:0] chk_mem_idx,
  input  logic [DATA_W-1:0] chk_reg_data,
  input  logic [DATA_W-1:0] chk_mem_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [MEM_AW-1:0] fail_idx
);

  localparam int CW = 6;
  localparam logic [CW-1:0] NOPS = CW'(NUM_OPS);

  if (NUM_OPS < 1 || NUM_OPS > 30) begin : g_bad_num_ops
    $error("mips_ldst_seq: NUM_OPS must be in 1..30");
  end
  if (2 * NUM_OPS > MEM_DEPTH) begin : g_bad_depth
    $error("mips_ldst_seq: 2*NUM_OPS must not exceed MEM_DEPTH");
  end
  if (MEM_AW < $clog2(MEM_DEPTH)) begin : g_bad_aw
    $error("mips_ldst_seq: MEM_AW too narrow for MEM_DEPTH");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          state;
  logic [1:0]      mode_q;
  logic [CW-1:0]   cnt;
  logic            mismatch;

  assign mismatch = (chk_reg_data != chk_mem_data);

  // Position k of a sweep: mode 11 runs all LW ops first, then all SW ops.
  function automatic logic seq_is_sw(input logic [1:0] m, input logic [CW-1:0] k);
    return (m == 2'b10) || (m == 2'b11 && k >= NOPS);
  endfunction

  function automatic logic [4:0] seq_op(input logic [1:0] m, input logic [CW-1:0] k);
    logic [CW-1:0] j;
    j = (m == 2'b11 && k >= NOPS) ? k - NOPS : k;
    return 5'(j);
  endfunction

  function automatic logic [CW-1:0] seq_len(input logic [1:0] m);
    return (m == 2'b11) ? CW'(2 * NUM_OPS) : NOPS;
  endfunction

  function automatic logic [31:0] op_word(input logic is_sw, input logic [4:0] i);
    logic [4:0]  rt;
    logic [15:0] imm;
    rt  = i + 5'd1;
    imm = is_sw ? 16'(NUM_OPS) + 16'(i) : 16'(i);
    return {(is_sw ? 6'h2B : 6'h23), 5'd0, rt, imm};
  endfunction

  function automatic logic [31:0] issue_word(input logic [1:0] m, input logic [CW-1:0] k);
    return op_word(seq_is_sw(m, k), seq_op(m, k));
  endfunction

  function automatic logic [4:0] pair_reg_idx(input logic [1:0] m, input logic [CW-1:0] k);
    return seq_op(m, k) + 5'd1;
  endfunction

  // LW pairs look at mem[i], SW pairs at mem[NUM_OPS+i].
  function automatic logic [MEM_AW-1:0] pair_mem_idx(input logic [1:0] m, input logic [CW-1:0] k);
    logic [4:0] i;
    i = seq_op(m, k);
    return seq_is_sw(m, k) ? MEM_AW'(NUM_OPS) + MEM_AW'(i) : MEM_AW'(i);
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      mode_q      <= 2'b00;
      cnt         <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      chk_reg_idx <= '0;
      chk_mem_idx <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      fail_idx    <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start && mode != 2'b00) begin
            state       <= S_ISSUE;
            mode_q      <= mode;
            cnt         <= CW'(1);
            instr_valid <= 1'b1;
            instr       <= issue_word(mode, '0);
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            fail_idx    <= '0;
          end
        end

        // cnt is the index of the next op to present
        S_ISSUE: begin
          if (cnt == seq_len(mode_q)) begin
            state       <= S_DRAIN;
            instr_valid <= 1'b0;
            instr       <= '0;
          end else begin
            instr <= issue_word(mode_q, cnt);
            cnt   <= cnt + CW'(1);
          end
        end

        S_DRAIN: begin
          state       <= S_CHECK;
          cnt         <= '0;
          chk_reg_idx <= pair_reg_idx(mode_q, '0);
          chk_mem_idx <= pair_mem_idx(mode_q, '0);
        end

        // cnt is the pair whose index is on the bus; its data is judged at the end of this cycle
        S_CHECK: begin
          if (cnt == seq_len(mode_q)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 8'd0);
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt + CW'(1) < seq_len(mode_q)) begin
              chk_reg_idx <= pair_reg_idx(mode_q, cnt + CW'(1));
              chk_mem_idx <= pair_mem_idx(mode_q, cnt + CW'(1));
            end else begin
              chk_reg_idx <= '0;
              chk_mem_idx <= '0;
            end
            if (mismatch) begin
              if (err_count == 8'd0) begin
                fail_idx <= chk_mem_idx;
              end
`ifdef LDST_SEQ_STOP_ON_ERR_EN
              err_count   <= 8'd1;
              state       <= S_DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              pass        <= 1'b0;
              chk_reg_idx <= '0;
              chk_mem_idx <= '0;
`else
              if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
              end
`endif
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_ldst_seq.sv
// Bench for mips_ldst_seq: stands in for the core, regfile and dmem, and predicts every sweep
// from the instruction formulas and pair ordering (vector table, corner sequences, random runs).
`timescale 1ns/1ps
module tb_mips_ldst_seq;

  localparam int N  = 5;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [4:0]    chk_reg_idx;
  logic [AW-1:0] chk_mem_idx;
  logic [31:0]   chk_reg_data;
  logic [31:0]   chk_mem_data;
  logic          busy;
  logic          done;
  logic          pass;
  logic [7:0]    err_count;
  logic [AW-1:0] fail_idx;

  logic [31:0] regs      [32];
  logic [31:0] dmem      [64];
  logic [31:0] init_regs [32];
  logic [31:0] init_mem  [64];
  logic [63:0] corrupt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] mask;
    bit          poke;
    int          err;
    int          fail;
    bit          pass;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  // Async read ports of the emulated regfile and dmem; corrupt flips bit 0 of chosen dmem words.
  assign chk_reg_data = regs[chk_reg_idx];
  assign chk_mem_data = dmem[chk_mem_idx] ^ {31'd0, corrupt[chk_mem_idx]};

  mips_ldst_seq #(
    .NUM_OPS  (N),
    .DATA_W   (32),
    .MEM_DEPTH(64),
    .MEM_AW   (AW)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .start       (start),
    .mode        (mode),
    .instr_valid (instr_valid),
    .instr       (instr),
    .chk_reg_idx (chk_reg_idx),
    .chk_mem_idx (chk_mem_idx),
    .chk_reg_data(chk_reg_data),
    .chk_mem_data(chk_mem_data),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_count   (err_count),
    .fail_idx    (fail_idx)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] expWord(input logic [1:0] m, input int k);
    bit sw;
    int i;
    sw = (m == 2'b10) || (m == 2'b11 && k >= N);
    i  = (m == 2'b11 && k >= N) ? k - N : k;
    if (sw) return 32'hAC000000 | 32'((i + 1) << 16) | 32'(N + i);
    return 32'h8C000000 | 32'((i + 1) << 16) | 32'(i);
  endfunction

  // Sweep outcome from the pair list: pair k reads mem[k] (LW / LW+SW) or mem[N+k] (SW only).
  function automatic void predict(input logic [1:0] m, input logic [63:0] mask,
                                  output int e, output int f, output bit p, output int lat);
    int nops;
    int first;
    nops  = (m == 2'b11) ? 2 * N : N;
    e     = 0;
    f     = 0;
    first = -1;
    for (int k = 0; k < nops; k++) begin
      int midx;
      midx = (m == 2'b10) ? N + k : k;
      if (mask[midx]) begin
        e++;
        if (first < 0) begin
          first = k;
          f     = midx;
        end
      end
    end
    lat = 2 * nops + 2;
`ifdef LDST_SEQ_STOP_ON_ERR_EN
    if (first >= 0) begin
      e   = 1;
      lat = nops + first + 2;
    end
`endif
    p = (e == 0);
  endfunction

  // The core commits a valid LW/SW with base register $0.
  task automatic executeInstr(input logic [31:0] w);
    logic [4:0]  rt;
    logic [15:0] imm;
    rt  = w[20:16];
    imm = w[15:0];
    if (imm < 16'd64 && rt != 5'd0) begin
      if (w[31:26] == 6'h23) regs[rt] = dmem[imm[5:0]];
      else if (w[31:26] == 6'h2B) dmem[imm[5:0]] = regs[rt];
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] m, input logic [63:0] mask,
                               input bit poke, input int exp_err, input int exp_fail,
                               input bit exp_pass, input int exp_lat);
    int nops;
    int edges;
    int k;
    int bad;
    bit seen_done;
    nops = (m == 2'b11) ? 2 * N : N;
    for (int i = 0; i < 64; i++) begin
      dmem[i]     = $urandom;
      init_mem[i] = dmem[i];
    end
    for (int i = 0; i < 32; i++) begin
      regs[i]      = (i == 0) ? 32'd0 : $urandom;
      init_regs[i] = regs[i];
    end
    corrupt   = mask;
    mode      = m;
    start     = 1'b1;
    edges     = 0;
    k         = 0;
    bad       = 0;
    seen_done = 1'b0;
    while (!seen_done && edges < 300) begin
      @(negedge clk);
      edges++;
      if (edges == 1) begin
        checkOutput({tag, "_entry_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_entry_err_fail"}, {16'd0, err_count, 2'd0, fail_idx}, 32'd0);
        checkOutput({tag, "_entry_done_pass"}, {30'd0, done, pass}, 32'd0);
      end
      if (instr_valid) begin
        if (k < nops) checkOutput($sformatf("%s_instr%0d", tag, k), instr, expWord(m, k));
        else bad++;
        executeInstr(instr);
        k++;
        if (chk_reg_idx != 5'd0 || chk_mem_idx != '0) bad++;
      end else if (instr != 32'd0) begin
        bad++;
      end
      if (busy && done) bad++;
      seen_done = done;
      start = poke && (edges == 3 || edges == 10 || edges == 14);
      mode  = start ? ((m == 2'b10) ? 2'b11 : 2'b10) : m;
    end
    start = 1'b0;
    mode  = m;
    checkOutput({tag, "_done_seen"}, 32'(seen_done), 32'd1);
    checkOutput({tag, "_latency"}, 32'(edges - 1), 32'(exp_lat));
    checkOutput({tag, "_issued"}, 32'(k), 32'(nops));
    checkOutput({tag, "_protocol"}, 32'(bad), 32'd0);
    checkOutput({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
    checkOutput({tag, "_fail_idx"}, 32'(fail_idx), 32'(exp_fail));
    checkOutput({tag, "_pass"}, 32'(pass), 32'(exp_pass));
    checkOutput({tag, "_idle_outs"}, {27'd0, busy, instr_valid, 3'd0} | 32'(chk_reg_idx) | 32'(chk_mem_idx), 32'd0);
    for (int i = 0; i < N; i++) begin
      if (m != 2'b10) checkOutput($sformatf("%s_reg%0d", tag, i + 1), regs[i + 1], init_mem[i]);
      if (m != 2'b01) checkOutput($sformatf("%s_mem%0d", tag, N + i), dmem[N + i],
                                  (m == 2'b11) ? init_mem[i] : init_regs[i + 1]);
    end
  endtask

  initial begin
    int cnt_bad;
    int e;
    int f;
    bit p;
    int lat;
    logic [1:0]  rm;
    logic [63:0] rmask;

    // Vector table: mode, corrupted dmem words, start pokes while busy, expected err/fail/pass/latency.
    vecs[0] = '{2'b01, 64'd0,                    1'b0, 0, 0, 1'b1, 12};
    vecs[1] = '{2'b11, 64'd0,                    1'b0, 0, 0, 1'b1, 22};
`ifdef LDST_SEQ_STOP_ON_ERR_EN
    vecs[2] = '{2'b01, 64'h14,                   1'b0, 1, 2, 1'b0, 9};
`else
    vecs[2] = '{2'b01, 64'h14,                   1'b0, 2, 2, 1'b0, 12};
`endif
    vecs[3] = '{2'b01, 64'd0,                    1'b0, 0, 0, 1'b1, 12};
    vecs[4] = '{2'b10, 64'd0,                    1'b0, 0, 0, 1'b1, 12};
`ifdef LDST_SEQ_STOP_ON_ERR_EN
    vecs[5] = '{2'b10, 64'h80,                   1'b0, 1, 7, 1'b0, 9};
    vecs[6] = '{2'b11, 64'h242,                  1'b0, 1, 1, 1'b0, 13};
    vecs[7] = '{2'b11, 64'h1,                    1'b1, 1, 0, 1'b0, 12};
`else
    vecs[5] = '{2'b10, 64'h80,                   1'b0, 1, 7, 1'b0, 12};
    vecs[6] = '{2'b11, 64'h242,                  1'b0, 3, 1, 1'b0, 22};
    vecs[7] = '{2'b11, 64'h1,                    1'b1, 1, 0, 1'b0, 22};
`endif
    vecs[8] = '{2'b10, 64'h8,                    1'b0, 0, 0, 1'b1, 12};

    rst     = 1'b1;
    start   = 1'b0;
    mode    = 2'b00;
    corrupt = '0;
    for (int i = 0; i < 64; i++) dmem[i] = '0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_flags", {27'd0, instr_valid, busy, done, pass, 1'b0}, 32'd0);
    checkOutput("reset_instr", instr, 32'd0);
    checkOutput("reset_counts", {10'd0, err_count, fail_idx, 3'd0, chk_reg_idx}, 32'd0);
    checkOutput("reset_chk_mem_idx", 32'(chk_mem_idx), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // start with mode 00 from IDLE must not launch anything
    start = 1'b1;
    mode  = 2'b00;
    @(negedge clk);
    start   = 1'b0;
    cnt_bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (instr_valid || busy || done) cnt_bad++;
    end
    checkOutput("mode00_idle_ignored", 32'(cnt_bad), 32'd0);

    for (int v = 0; v < 9; v++) begin
      applyStimulus($sformatf("vec%0d", v), vecs[v].mode, vecs[v].mask, vecs[v].poke,
                    vecs[v].err, vecs[v].fail, vecs[v].pass, vecs[v].lat);
      @(negedge clk);
    end

    // start with mode 00 from DONE must leave the result standing
    start = 1'b1;
    mode  = 2'b00;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("mode00_done_ignored", {30'd0, done, instr_valid}, 32'd2);

    for (int r = 0; r < 16; r++) begin
      rm    = 2'($urandom_range(1, 3));
      rmask = '0;
      for (int b = 0; b < 2 * N; b++) begin
        if ($urandom_range(0, 3) == 0) rmask[b] = 1'b1;
      end
      predict(rm, rmask, e, f, p, lat);
      applyStimulus($sformatf("rnd%0d", r), rm, rmask, 1'b0, e, f, p, lat);
      @(negedge clk);
    end

    // Reset during the third ISSUE cycle aborts straight to IDLE
    corrupt = '0;
    mode    = 2'b01;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("abort_pre_instr", instr, expWord(2'b01, 2));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_flags", {28'd0, instr_valid, busy, done, pass}, 32'd0);
    checkOutput("abort_instr", instr, 32'd0);
    rst     = 1'b0;
    cnt_bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (instr_valid || busy || done) cnt_bad++;
    end
    checkOutput("abort_stays_idle", 32'(cnt_bad), 32'd0);
    applyStimulus("after_abort", 2'b01, 64'd0, 1'b0, 0, 0, 1'b1, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
